// File: rtl/segment_mask_multi.sv
// Multi-channel run-length segment mask. Loads segment records from the ioctl stream into a RAM.
// During active video it walks CHANNELS record lists and reports the winning channel's segment id per pixel.
module segment_mask_multi #(
  parameter int  CLOCK_RATIO  = 3,
  parameter int  CHANNELS     = 1,
  parameter int  COORD_WIDTH  = 10,
  parameter int  ID_WIDTH     = 10,
  parameter int  DEPTH        = 32768,
  localparam int ADDR_WIDTH   = $clog2(DEPTH),
  localparam int RECORD_BITS  = ID_WIDTH + 3 * COORD_WIDTH,
  localparam int RECORD_BYTES = (RECORD_BITS + 7) / 8,
  localparam int CH_WIDTH     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ioctl_wr,
  input  logic [15:0]            ioctl_dout,
  input  logic                   vblank,
  input  logic                   hblank,
  input  logic [COORD_WIDTH-1:0] video_x,
  input  logic [COORD_WIDTH-1:0] video_y,
  output logic [ID_WIDTH-1:0]    segment_id,
  output logic                   has_segment,
  output logic [CH_WIDTH-1:0]    segment_channel,
  output logic [ADDR_WIDTH:0]    load_records,
  output logic                   load_overflow
);

  localparam int SHIFT_BITS = RECORD_BYTES * 8;
  localparam int HDR_BYTES  = 2 * CHANNELS;
  localparam int HDR_W      = $clog2(HDR_BYTES + 1);
  localparam int RCNT_W     = $clog2(RECORD_BYTES + 1);
  localparam int CNT_W      = $clog2(CLOCK_RATIO);

  if (CLOCK_RATIO < CHANNELS + 2) begin : g_ratioCheck
    $error("segment_mask_multi: CLOCK_RATIO must be at least CHANNELS+2");
  end
  if (CHANNELS < 1 || CHANNELS > 4) begin : g_channelCheck
    $error("segment_mask_multi: CHANNELS must be 1..4");
  end

  logic                  r_resetQ;
  logic                  w_resetRise;
  logic [15:0]           r_word;
  logic [1:0]            r_pending;
  logic                  w_byteValid;
  logic [7:0]            w_byte;
  logic [HDR_W-1:0]      r_hdrCount;
  logic [7:0]            r_baseLo;
  logic [ADDR_WIDTH-1:0] r_base [CHANNELS];
  logic [SHIFT_BITS-1:0] r_recShift;
  logic [RCNT_W-1:0]     r_recCount;
  logic                  r_wrPending;
  logic [ADDR_WIDTH:0]   r_writeAddr;
  logic                  r_overflow;
  logic                  w_wrInRange;

  assign w_resetRise  = reset & ~r_resetQ;
  assign w_byteValid  = (r_pending != 2'd0);
  assign w_byte       = r_word[7:0];
  assign w_wrInRange  = (r_writeAddr < (ADDR_WIDTH+1)'(DEPTH));
  assign load_records  = r_writeAddr;
  assign load_overflow = r_overflow;

  // The loader only clears on the rising edge of reset so a table can be downloaded while reset is held.
  always_ff @(posedge clk) begin
    r_resetQ <= reset;
    if (w_resetRise) begin
      r_word      <= '0;
      r_pending   <= 2'd0;
      r_hdrCount  <= '0;
      r_baseLo    <= '0;
      r_recShift  <= '0;
      r_recCount  <= '0;
      r_wrPending <= 1'b0;
      r_writeAddr <= '0;
      r_overflow  <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) r_base[c] <= '0;
    end else begin
      if (ioctl_wr) begin
        r_word    <= ioctl_dout;
        r_pending <= 2'd2;
      end else if (w_byteValid) begin
        r_word    <= {8'h00, r_word[15:8]};
        r_pending <= r_pending - 2'd1;
      end
      r_wrPending <= 1'b0;
      if (w_byteValid) begin
        if (r_hdrCount < HDR_W'(HDR_BYTES)) begin
          for (int c = 0; c < CHANNELS; c++) begin
            if (r_hdrCount == HDR_W'(2 * c)) r_baseLo <= w_byte;
            if (r_hdrCount == HDR_W'(2 * c + 1)) r_base[c] <= ADDR_WIDTH'({w_byte, r_baseLo});
          end
          r_hdrCount <= r_hdrCount + HDR_W'(1);
        end else begin
          r_recShift <= {w_byte, r_recShift[SHIFT_BITS-1:8]};
          if (r_recCount == RCNT_W'(RECORD_BYTES - 1)) begin
            r_recCount  <= '0;
            r_wrPending <= 1'b1;
          end else begin
            r_recCount <= r_recCount + RCNT_W'(1);
          end
        end
      end
      if (r_wrPending) begin
        if (!w_wrInRange) r_overflow <= 1'b1;
        if (r_writeAddr != '1) r_writeAddr <= r_writeAddr + (ADDR_WIDTH+1)'(1);
      end
    end
  end

  logic [RECORD_BITS-1:0] r_mem [DEPTH];
  logic [RECORD_BITS-1:0] r_ramQ;
  logic                   w_rdAny;
  logic                   w_ramGrant;
  logic [CH_WIDTH-1:0]    w_rdChan;
  logic [ADDR_WIDTH-1:0]  w_rdAddr;

  // Single-port RAM: a pending record write takes the port, and the displaced refill retries next pixel.
  always_ff @(posedge clk) begin
    if (r_wrPending) begin
      if (w_wrInRange) r_mem[r_writeAddr[ADDR_WIDTH-1:0]] <= r_recShift[RECORD_BITS-1:0];
    end else begin
      r_ramQ <= r_mem[w_rdAddr];
    end
  end

  logic [CNT_W-1:0]       r_vidCounter;
  logic                   w_phase0;
  logic                   w_blank;
  logic [ADDR_WIDTH-1:0]  r_ptr    [CHANNELS];
  logic [RECORD_BITS-1:0] r_next   [CHANNELS];
  logic [COORD_WIDTH-1:0] r_remain [CHANNELS];
  logic [ID_WIDTH-1:0]    r_curId  [CHANNELS];
  logic [CHANNELS-1:0]    r_active;
  logic [CHANNELS-1:0]    r_done;
  logic [CHANNELS-1:0]    r_refill;
  logic                   r_rdValid;
  logic [CH_WIDTH-1:0]    r_rdChan;
  logic [ID_WIDTH-1:0]    w_nextId  [CHANNELS];
  logic [COORD_WIDTH-1:0] w_nextX   [CHANNELS];
  logic [COORD_WIDTH-1:0] w_nextY   [CHANNELS];
  logic [COORD_WIDTH-1:0] w_nextLen [CHANNELS];
  logic [CHANNELS-1:0]    w_match;
  logic [CHANNELS-1:0]    w_hit;

  assign w_phase0   = (r_vidCounter == '0);
  assign w_blank    = vblank | hblank;
  assign w_ramGrant = w_rdAny & ~r_wrPending;

  always_ff @(posedge clk) begin
    if (reset) r_vidCounter <= CNT_W'(CLOCK_RATIO - 1);
    else if (w_phase0) r_vidCounter <= CNT_W'(CLOCK_RATIO - 1);
    else r_vidCounter <= r_vidCounter - CNT_W'(1);
  end

  // Channel c owns the RAM port in the (c+1)-th cycle after phase 0.
  always_comb begin
    w_rdAny  = 1'b0;
    w_rdChan = '0;
    w_rdAddr = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (r_vidCounter == CNT_W'(CLOCK_RATIO - 1 - c) && (r_refill[c] || vblank)) begin
        w_rdAny  = 1'b1;
        w_rdChan = CH_WIDTH'(c);
        w_rdAddr = r_ptr[c];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      w_nextId[c]  = r_next[c][ID_WIDTH-1:0];
      w_nextX[c]   = r_next[c][ID_WIDTH +: COORD_WIDTH];
      w_nextY[c]   = r_next[c][ID_WIDTH + COORD_WIDTH +: COORD_WIDTH];
      w_nextLen[c] = r_next[c][ID_WIDTH + 2 * COORD_WIDTH +: COORD_WIDTH];
      w_match[c]   = !r_done[c] && (w_nextLen[c] != '0) &&
                     (video_x == w_nextX[c]) && (video_y == w_nextY[c]);
      w_hit[c]     = !w_blank && (w_match[c] || r_active[c]);
    end
  end

  // A start always wins over a running segment; an end marker only blocks further starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdValid <= 1'b0;
      r_rdChan  <= '0;
      r_active  <= '0;
      r_done    <= '0;
      r_refill  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_ptr[c]    <= '0;
        r_next[c]   <= '0;
        r_remain[c] <= '0;
        r_curId[c]  <= '0;
      end
    end else begin
      r_rdValid <= w_ramGrant;
      r_rdChan  <= w_rdChan;
      for (int c = 0; c < CHANNELS; c++) begin
        if (r_rdValid && r_rdChan == CH_WIDTH'(c)) r_next[c] <= r_ramQ;
        if (w_ramGrant && w_rdChan == CH_WIDTH'(c)) r_refill[c] <= 1'b0;
        if (vblank) begin
          r_ptr[c]    <= r_base[c];
          r_active[c] <= 1'b0;
          r_done[c]   <= 1'b0;
        end else if (w_phase0) begin
          if (hblank) begin
            r_active[c] <= 1'b0;
          end else if (w_match[c]) begin
            r_active[c] <= (w_nextLen[c] > COORD_WIDTH'(1));
            r_remain[c] <= w_nextLen[c] - COORD_WIDTH'(1);
            r_curId[c]  <= w_nextId[c];
            r_ptr[c]    <= r_ptr[c] + ADDR_WIDTH'(1);
            r_refill[c] <= 1'b1;
          end else begin
            if (!r_done[c] && w_nextLen[c] == '0) r_done[c] <= 1'b1;
            if (r_active[c]) begin
              r_remain[c] <= r_remain[c] - COORD_WIDTH'(1);
              r_active[c] <= (r_remain[c] != COORD_WIDTH'(1));
            end
          end
        end
      end
    end
  end

  logic                w_anyHit;
  logic [CH_WIDTH-1:0] w_winCh;
  logic [ID_WIDTH-1:0] w_winId;

  always_comb begin
    w_anyHit = 1'b0;
    w_winCh  = segment_channel;
    w_winId  = segment_id;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (w_hit[c]) begin
        w_anyHit = 1'b1;
        w_winCh  = CH_WIDTH'(c);
        w_winId  = w_match[c] ? w_nextId[c] : r_curId[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      segment_id      <= '0;
      has_segment     <= 1'b0;
      segment_channel <= '0;
    end else if (w_phase0) begin
      has_segment <= w_anyHit;
      if (w_anyHit) begin
        segment_id      <= w_winId;
        segment_channel <= w_winCh;
      end
    end
  end

endmodule

// File: tb/tb_segment_mask_multi.sv
// Directed bench for segment_mask_multi: downloads small record tables under reset and
// renders tiny frames, comparing every pixel with hand-derived expectations.
module tb_segment_mask_multi;

  localparam int CR       = 4;
  localparam int CHANNELS = 2;
  localparam int CW       = 10;
  localparam int IW       = 10;
  localparam int DEPTH    = 16;
  localparam int AW       = $clog2(DEPTH);
  localparam int CHW      = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ioctl_wr = 1'b0;
  logic [15:0]   ioctl_dout = '0;
  logic          vblank = 1'b1;
  logic          hblank = 1'b0;
  logic [CW-1:0] video_x = '0;
  logic [CW-1:0] video_y = '0;
  logic [IW-1:0] segment_id;
  logic          has_segment;
  logic [CHW-1:0] segment_channel;
  logic [AW:0]   load_records;
  logic          load_overflow;

  segment_mask_multi #(
    .CLOCK_RATIO(CR), .CHANNELS(CHANNELS), .COORD_WIDTH(CW), .ID_WIDTH(IW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
    .vblank(vblank), .hblank(hblank), .video_x(video_x), .video_y(video_y),
    .segment_id(segment_id), .has_segment(has_segment), .segment_channel(segment_channel),
    .load_records(load_records), .load_overflow(load_overflow)
  );

  always #5 clk = ~clk;

  typedef struct { int y; int x; int id; int ch; } hit_t;
  hit_t       expHits[$];
  logic [7:0] loadBytes[$];
  int testsRun = 0;
  int testsFailed = 0;
  int lastId = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic addHeader(input int b0, input int b1);
    logic [15:0] w0, w1;
    w0 = b0[15:0];
    w1 = b1[15:0];
    loadBytes.push_back(w0[7:0]);
    loadBytes.push_back(w0[15:8]);
    loadBytes.push_back(w1[7:0]);
    loadBytes.push_back(w1[15:8]);
  endtask

  task automatic addRecord(input int id, input int x, input int y, input int len);
    logic [39:0] rec;
    rec = {len[9:0], y[9:0], x[9:0], id[9:0]};
    for (int b = 0; b < 5; b++) loadBytes.push_back(rec[8*b +: 8]);
  endtask

  task automatic addHit(input int y, input int x, input int id, input int ch);
    hit_t h;
    h.y = y; h.x = x; h.id = id; h.ch = ch;
    expHits.push_back(h);
  endtask

  // Raises reset (clearing the loader), downloads the queued bytes while reset stays high.
  task automatic downloadTable();
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    if (loadBytes.size() % 2 != 0) loadBytes.push_back(8'h00);
    for (int i = 0; i < loadBytes.size(); i += 2) begin
      ioctl_wr   = 1'b1;
      ioctl_dout = {loadBytes[i+1], loadBytes[i]};
      @(negedge clk);
      ioctl_wr = 1'b0;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    loadBytes.delete();
    lastId = 0;
  endtask

  // One pixel period; the last posedge of the window is the DUT's phase-0 edge.
  task automatic applyStimulus(input logic vb, input logic hb, input int x, input int y);
    @(negedge clk);
    reset   = 1'b0;
    vblank  = vb;
    hblank  = hb;
    video_x = x[CW-1:0];
    video_y = y[CW-1:0];
    repeat (CR) @(posedge clk);
    #1;
  endtask

  task automatic checkPixel(input int x, input int y);
    bit found;
    int id, ch;
    found = 1'b0; id = 0; ch = 0;
    foreach (expHits[i]) begin
      if (expHits[i].x == x && expHits[i].y == y) begin
        found = 1'b1; id = expHits[i].id; ch = expHits[i].ch;
      end
    end
    checkOutput($sformatf("has y%0d x%0d", y, x), 32'(has_segment), found ? 32'd1 : 32'd0);
    if (found) begin
      checkOutput($sformatf("id y%0d x%0d", y, x), 32'(segment_id), 32'(id));
      checkOutput($sformatf("ch y%0d x%0d", y, x), 32'(segment_channel), 32'(ch));
      lastId = id;
    end
  endtask

  task automatic runFrame(input int xStart, input int xCount, input int yCount);
    repeat (2) begin
      applyStimulus(1'b1, 1'b0, 0, 0);
      checkOutput("vblank has", 32'(has_segment), 32'd0);
    end
    for (int y = 0; y < yCount; y++) begin
      for (int i = 0; i < xCount; i++) begin
        applyStimulus(1'b0, 1'b0, xStart + i, y);
        checkPixel(xStart + i, y);
      end
      for (int h = 0; h < 2; h++) begin
        applyStimulus(1'b0, 1'b1, xStart + xCount + h, y);
        checkOutput($sformatf("hblank has y%0d", y), 32'(has_segment), 32'd0);
        checkOutput($sformatf("hblank id hold y%0d", y), 32'(segment_id), 32'(lastId));
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);

    // Single-channel list with back-to-back records; channel 1 starts on an end marker.
    addHeader(0, 3);
    addRecord(7, 20, 0, 1);
    addRecord(8, 21, 0, 2);
    addRecord(5, 10, 2, 3);
    addRecord(0, 0, 0, 0);
    downloadTable();
    checkOutput("reset has", 32'(has_segment), 32'd0);
    checkOutput("reset id", 32'(segment_id), 32'd0);
    checkOutput("reset ch", 32'(segment_channel), 32'd0);
    checkOutput("load A records", 32'(load_records), 32'd4);
    checkOutput("load A overflow", 32'(load_overflow), 32'd0);
    expHits.delete();
    addHit(0, 20, 7, 0); addHit(0, 21, 8, 0); addHit(0, 22, 8, 0);
    addHit(2, 10, 5, 0); addHit(2, 11, 5, 0); addHit(2, 12, 5, 0);
    runFrame(8, 18, 3);
    runFrame(8, 18, 3);

    // Overlapping channels: the lower index wins while both are hit.
    addHeader(0, 2);
    addRecord(1, 4, 0, 4);
    addRecord(0, 0, 0, 0);
    addRecord(2, 2, 0, 8);
    addRecord(0, 0, 0, 0);
    downloadTable();
    checkOutput("load B records", 32'(load_records), 32'd4);
    expHits.delete();
    addHit(0, 2, 2, 1); addHit(0, 3, 2, 1);
    addHit(0, 4, 1, 0); addHit(0, 5, 1, 0); addHit(0, 6, 1, 0); addHit(0, 7, 1, 0);
    addHit(0, 8, 2, 1); addHit(0, 9, 2, 1);
    runFrame(0, 12, 2);

    // DEPTH+1 records: the last one must be dropped, not wrapped onto record 0.
    addHeader(0, 1);
    addRecord(9, 3, 1, 2);
    for (int i = 1; i < DEPTH; i++) addRecord(0, 0, 0, 0);
    addRecord(30, 6, 1, 1);
    downloadTable();
    checkOutput("load D records", 32'(load_records), 32'(DEPTH + 1));
    checkOutput("load D overflow", 32'(load_overflow), 32'd1);
    expHits.delete();
    addHit(1, 3, 9, 0); addHit(1, 4, 9, 0);
    runFrame(0, 8, 2);

    // Fresh load after a new reset edge: hblank truncation and start override.
    addHeader(0, 4);
    addRecord(20, 638, 1, 10);
    addRecord(21, 634, 2, 2);
    addRecord(11, 633, 3, 8);
    addRecord(12, 636, 3, 2);
    addRecord(0, 0, 0, 0);
    downloadTable();
    checkOutput("load C records", 32'(load_records), 32'd5);
    checkOutput("load C overflow", 32'(load_overflow), 32'd0);
    expHits.delete();
    addHit(1, 638, 20, 0); addHit(1, 639, 20, 0);
    addHit(2, 634, 21, 0); addHit(2, 635, 21, 0);
    addHit(3, 633, 11, 0); addHit(3, 634, 11, 0); addHit(3, 635, 11, 0);
    addHit(3, 636, 12, 0); addHit(3, 637, 12, 0);
    runFrame(632, 8, 4);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
